// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder
//   DVI 1.0 TMDS encoder for three channels. Each pixel clock it turns one
//   8-bit Red/Green/Blue pixel plus hs/vs/active_nblank into three 10-bit
//   code words for a 10:1 LSB-first serialiser. Data periods use the
//   transition-minimised, DC-balanced code. Blanking periods use control
//   tokens.
//
//   Ports
//     pixel_clk      in   1  pixel clock (only clock)
//     reset_n        in   1  synchronous active-low reset
//     Red/Green/Blue in   8  pixel data for channels 2/1/0
//     hs, vs         in   1  syncs (active low), control bits c0/c1 of channel 0
//     active_nblank  in   1  1 = data period, 0 = control period
//     tmds_ch0/1/2   out 10  registered code words, bit 0 is sent first
//
//   Build option
//     TMDS_INPUT_REG_EN: registers all inputs before encoding. Latency
//     becomes 2 cycles instead of 1.
module hdmi_tmds_encoder (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  input  logic       hs,
  input  logic       vs,
  input  logic       active_nblank,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  // Control token for {c1, c0}.
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = TOKEN_00;
      2'b01:   tok = TOKEN_01;
      2'b10:   tok = TOKEN_10;
      2'b11:   tok = TOKEN_11;
      default: tok = TOKEN_00;
    endcase
    return tok;
  endfunction

  // One data-period encode. Returns {next cnt, code word}.
  // Disparity arithmetic is done modulo 32 on 5 bits. Every intermediate
  // wrap cancels because the true result always fits in -16..15.
  function automatic logic [14:0] tmds_encode(input logic [7:0] d,
                                              input logic [4:0] cnt_in);
    logic [3:0] n1_d;
    logic [3:0] n1_q;
    logic       use_xnor;
    logic [8:0] q_m;
    logic [4:0] diff;
    logic [4:0] q8_x2;
    logic [4:0] nq8_x2;
    logic [9:0] code;
    logic [4:0] cnt_out;
    n1_d = 4'd0;
    for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, d[i]};
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && (d[0] == 1'b0));
    q_m[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) q_m[i] = ~(q_m[i-1] ^ d[i]);
      else          q_m[i] = q_m[i-1] ^ d[i];
    end
    q_m[8] = ~use_xnor;
    n1_q = 4'd0;
    for (int i = 0; i < 8; i++) n1_q = n1_q + {3'b000, q_m[i]};
    // n1 - n0 = 2*n1 - 8
    diff   = {n1_q, 1'b0} - 5'd8;
    q8_x2  = {3'b000, q_m[8], 1'b0};
    nq8_x2 = {3'b000, ~q_m[8], 1'b0};
    if ((cnt_in == 5'd0) || (n1_q == 4'd4)) begin
      code    = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      cnt_out = q_m[8] ? (cnt_in + diff) : (cnt_in - diff);
    end else if ((!cnt_in[4] && (n1_q > 4'd4)) || (cnt_in[4] && (n1_q < 4'd4))) begin
      // cnt is nonzero here, so a clear sign bit means cnt > 0
      code    = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_out = cnt_in + q8_x2 - diff;
    end else begin
      code    = {1'b0, q_m[8], q_m[7:0]};
      cnt_out = cnt_in + diff - nq8_x2;
    end
    return {cnt_out, code};
  endfunction

  logic [7:0]  red_s, green_s, blue_s;
  logic        hs_s, vs_s, de_s;
  logic [4:0]  cnt0_r, cnt1_r, cnt2_r;
  logic [14:0] enc0_s, enc1_s, enc2_s;

`ifdef TMDS_INPUT_REG_EN
  logic [7:0] red_r, green_r, blue_r;
  logic       hs_r, vs_r, de_r;

  // Input register: cleared to blanking with syncs inactive.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      red_r   <= 8'd0;
      green_r <= 8'd0;
      blue_r  <= 8'd0;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      de_r    <= 1'b0;
    end else begin
      red_r   <= Red;
      green_r <= Green;
      blue_r  <= Blue;
      hs_r    <= hs;
      vs_r    <= vs;
      de_r    <= active_nblank;
    end
  end

  assign red_s   = red_r;
  assign green_s = green_r;
  assign blue_s  = blue_r;
  assign hs_s    = hs_r;
  assign vs_s    = vs_r;
  assign de_s    = de_r;
`else
  assign red_s   = Red;
  assign green_s = Green;
  assign blue_s  = Blue;
  assign hs_s    = hs;
  assign vs_s    = vs;
  assign de_s    = active_nblank;
`endif

  // Combinational encode of all three channels from their current disparity.
  always_comb begin
    enc0_s = tmds_encode(blue_s,  cnt0_r);
    enc1_s = tmds_encode(green_s, cnt1_r);
    enc2_s = tmds_encode(red_s,   cnt2_r);
  end

  // Output and disparity registers. Blanking emits tokens and clears cnt.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      tmds_ch0 <= TOKEN_00;
      tmds_ch1 <= TOKEN_00;
      tmds_ch2 <= TOKEN_00;
      cnt0_r   <= 5'd0;
      cnt1_r   <= 5'd0;
      cnt2_r   <= 5'd0;
    end else if (de_s) begin
      tmds_ch0 <= enc0_s[9:0];
      tmds_ch1 <= enc1_s[9:0];
      tmds_ch2 <= enc2_s[9:0];
      cnt0_r   <= enc0_s[14:10];
      cnt1_r   <= enc1_s[14:10];
      cnt2_r   <= enc2_s[14:10];
    end else begin
      tmds_ch0 <= ctrl_token({vs_s, hs_s});
      tmds_ch1 <= TOKEN_00;
      tmds_ch2 <= TOKEN_00;
      cnt0_r   <= 5'd0;
      cnt1_r   <= 5'd0;
      cnt2_r   <= 5'd0;
    end
  end

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Self-checking bench for hdmi_tmds_encoder.
// A scoreboard queues each expected output, tagged with the clock edge at
// which it is due, and pops it when that edge has passed.
module tb_hdmi_tmds_encoder;

`ifdef TMDS_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       pixel_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] Red = 8'd0, Green = 8'd0, Blue = 8'd0;
  logic       hs = 1'b1, vs = 1'b1, active_nblank = 1'b0;
  logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;

  always #5 pixel_clk = ~pixel_clk;

  hdmi_tmds_encoder dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .Red(Red), .Green(Green), .Blue(Blue),
    .hs(hs), .vs(vs), .active_nblank(active_nblank),
    .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mcnt[3];
  int trk_on = 0;
  int rd = 0;

  int          q_due[$];
  logic [29:0] q_exp[$];
  logic [14:0] q_cnt[$];
  string       q_name[$];
  int          q_trk[$];

  // Golden encoder for one channel; updates mcnt[ch].
  task automatic model_ch(input int ch, input logic [7:0] d, output logic [9:0] code);
    int n1d, n1, n0;
    logic xn;
    logic [8:0] qm;
    n1d = $countones(d);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (mcnt[ch] == 0 || n1 == n0) begin
      code = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      mcnt[ch] = mcnt[ch] + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
      code = {1'b1, qm[8], ~qm[7:0]};
      mcnt[ch] = mcnt[ch] + (qm[8] ? 2 : 0) + (n0 - n1);
    end else begin
      code = {1'b0, qm[8], qm[7:0]};
      mcnt[ch] = mcnt[ch] + (n1 - n0) - (qm[8] ? 0 : 2);
    end
  endtask

  task automatic model_pixel(input logic [7:0] r, g, b, input logic h, v, de,
                             output logic [29:0] e);
    logic [9:0] c0, c1, c2;
    if (de) begin
      model_ch(0, b, c0);
      model_ch(1, g, c1);
      model_ch(2, r, c2);
    end else begin
      mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
      case ({v, h})
        2'b00:   c0 = T00;
        2'b01:   c0 = T01;
        2'b10:   c0 = T10;
        default: c0 = T11;
      endcase
      c1 = T00;
      c2 = T00;
    end
    e = {c2, c1, c0};
  endtask

  function automatic logic [14:0] model_cnt();
    return {5'(mcnt[2]), 5'(mcnt[1]), 5'(mcnt[0])};
  endfunction

  task automatic push(input int due, input logic [29:0] e, input logic [14:0] c, input string n);
    q_due.push_back(due);
    q_exp.push_back(e);
    q_cnt.push_back(c);
    q_name.push_back(n);
    q_trk.push_back(trk_on);
  endtask

  // Pop and compare every entry due at the current edge.
  task automatic check_out();
    int d;
    logic [29:0] e;
    logic [14:0] c, ac;
    string n;
    int t;
    while (q_due.size() != 0 && q_due[0] <= cyc) begin
      d = q_due.pop_front(); e = q_exp.pop_front(); c = q_cnt.pop_front();
      n = q_name.pop_front(); t = q_trk.pop_front();
      ac = {dut.cnt2_r, dut.cnt1_r, dut.cnt0_r};
      total++;
      if (tmds_ch0 !== e[9:0]) begin bad++; $display("FAIL %s ch0 got %b want %b (edge %0d)", n, tmds_ch0, e[9:0], d); end
      total++;
      if (tmds_ch1 !== e[19:10]) begin bad++; $display("FAIL %s ch1 got %b want %b (edge %0d)", n, tmds_ch1, e[19:10], d); end
      total++;
      if (tmds_ch2 !== e[29:20]) begin bad++; $display("FAIL %s ch2 got %b want %b (edge %0d)", n, tmds_ch2, e[29:20], d); end
      total++;
      if (ac !== c) begin bad++; $display("FAIL %s cnt got %h want %h (edge %0d)", n, ac, c, d); end
      if (t != 0) begin
        rd = rd + 2 * $countones(tmds_ch0) - 10;
        total++;
        if (rd > 10 || rd < -10) begin bad++; $display("FAIL %s running_disparity got %0d want |rd|<=10", n, rd); end
        total++;
        if ($signed(dut.cnt0_r) > 5'sd10 || $signed(dut.cnt0_r) < -5'sd10) begin
          bad++; $display("FAIL %s cnt0_range got %0d want |cnt|<=10", n, $signed(dut.cnt0_r));
        end
      end
    end
  endtask

  task automatic drive(input logic [7:0] r, g, b, input logic h, v, de, input logic rn);
    Red = r; Green = g; Blue = b; hs = h; vs = v; active_nblank = de; reset_n = rn;
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic step(input logic [7:0] r, g, b, input logic h, v, de, input string n);
    logic [29:0] e;
    drive(r, g, b, h, v, de, 1'b1);
    model_pixel(r, g, b, h, v, de, e);
    push(cyc + LAT, e, model_cnt(), n);
    tick();
  endtask

  task automatic step_fixed(input logic [7:0] r, g, b, input logic h, v, de,
                            input logic [29:0] e, input logic [14:0] c, input string n);
    logic [29:0] unused_e;
    drive(r, g, b, h, v, de, 1'b1);
    model_pixel(r, g, b, h, v, de, unused_e);
    push(cyc + LAT, e, c, n);
    tick();
  endtask

  task automatic step_reset(input string n);
    drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    q_due.delete(); q_exp.delete(); q_cnt.delete(); q_name.delete(); q_trk.delete();
    mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
    push(cyc + 1, {T00, T00, T00}, 15'd0, n);
    // The cleared input register is blanking with hs = vs = 1.
    if (LAT == 2) push(cyc + 2, {T00, T00, T11}, 15'd0, {n, "_clr"});
    tick();
  endtask

  task automatic rand_data(input int count, input string n);
    for (int i = 0; i < count; i++)
      step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, n);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step_reset("reset_hold");
    step_fixed(8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0, {T00, T00, T11}, 15'd0, "reset_release");
  endtask

  task automatic test_control_tokens();
    logic [9:0] tok[4];
    logic [1:0] c;
    tok[0] = T00; tok[1] = T01; tok[2] = T10; tok[3] = T11;
    for (int i = 0; i < 4; i++) begin
      c = 2'(i);
      step_fixed(8'($urandom), 8'($urandom), 8'($urandom), c[0], c[1], 1'b0,
                 {T00, T00, tok[i]}, 15'd0, "ctrl_token");
    end
  endtask

  task automatic test_disparity_run();
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "disp_blank");
    step_fixed(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, {3{10'h100}}, {3{5'b11000}}, "disp_px1");
    step_fixed(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, {3{10'h3FF}}, {3{5'b00010}}, "disp_px2");
  endtask

  task automatic test_saturated();
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "sat_blank");
    step_fixed(8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, {10'h100, 10'h200, 10'h100},
               {3{5'b11000}}, "sat_green");
  endtask

  task automatic test_back_to_back();
    rand_data(6, "b2b_data");
    step(8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 1'b0, "b2b_ctrl");
    rand_data(4, "b2b_resume");
    step(8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, "b2b_ctrl2");
    step(8'h10, 8'h8F, 8'hAA, 1'b1, 1'b1, 1'b1, "b2b_after");
  endtask

  task automatic test_random_dc();
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "dc_blank");
    rd = 0;
    trk_on = 1;
    rand_data(10000, "dc_random");
    trk_on = 0;
  endtask

  task automatic test_midline_reset();
    rand_data(5, "mid_pre");
    step_reset("mid_reset");
    rand_data(8, "mid_post");
  endtask

  initial begin
    mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
    test_reset();
    test_control_tokens();
    test_disparity_run();
    test_saturated();
    test_back_to_back();
    test_random_dc();
    test_midline_reset();
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, "tail");
    for (int i = 0; i < LAT; i++) tick();
    total++;
    if (q_due.size() != 0) begin
      bad++;
      $display("FAIL drain pending got %0d want 0", q_due.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_tmds_encoder.md
# hdmi_tmds_encoder

- Sits directly downstream of the VGA/NES video timing stage.
- Takes per-pixel 8-bit Red/Green/Blue plus hs, vs and active_nblank, and produces three 10-bit DVI 1.0 TMDS code words per pixel clock.
- Data periods use transition-minimised, DC-balanced encoding; blanking periods use control tokens.
- Outputs feed the HDMI serialiser: 10:1 OSERDES, LSB first.

## Interface
Parameters:
- none; all widths fixed by DVI 1.0.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of pixel_clk.
- Red  in  8  red pixel data; encoded on channel 2.
- Green  in  8  green pixel data; encoded on channel 1.
- Blue  in  8  blue pixel data; encoded on channel 0.
- hs  in  1  horizontal sync, active low; passed through as channel 0 control bit c0.
- vs  in  1  vertical sync, active low; passed through as channel 0 control bit c1.
- active_nblank  in  1  1 = data period, 0 = control period.
- tmds_ch0  out  10  channel 0 code word; bit 0 is transmitted first.
- tmds_ch1  out  10  channel 1 code word.
- tmds_ch2  out  10  channel 2 code word.

## Operation
- Three identical encoder instances. Each instance holds a 5-bit signed (two's complement) disparity counter `cnt`.
- Stage A (transition minimisation), for input byte D:
  - N1(D) = count of ones in D.
  - Use XNOR if N1(D) > 4, or if N1(D) == 4 and D[0] == 0. Otherwise use XOR.
  - q_m[0] = D[0]; q_m[i] = q_m[i-1] op D[i] for i = 1..7.
  - q_m[8] = 0 for XNOR, 1 for XOR.
- Stage B (DC balance), with n1/n0 = ones/zeros in q_m[7:0]:
  - Case 1: cnt == 0 or n1 == n0.
    - out[9] = ~q_m[8]; out[8] = q_m[8].
    - out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
    - cnt += q_m[8] ? (n1 - n0) : (n0 - n1).
  - Case 2: (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1).
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0 - n1).
  - Case 3: otherwise.
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1 - n0) - 2*(~q_m[8]).
- Control period (active_nblank == 0):
  - cnt is forced to 0.
  - Token selected by {c1, c0}: 00 → 10'b1101010100; 01 → 10'b0010101011; 10 → 10'b0101010100; 11 → 10'b1010101011.
  - Channel 0 uses {c1, c0} = {vs, hs}. Channels 1 and 2 always use {c1, c0} = 00.
- All disparity arithmetic is 5-bit signed. |cnt| never exceeds 10, so no saturation is needed.

## Timing
- Stage A and Stage B together form one combinational path feeding the output register.
- Latency: inputs sampled at edge k appear on tmds_ch* after edge k. This is 1 cycle without TMDS_INPUT_REG_EN.
- Control/data classification uses active_nblank from the same cycle as the pixel data, so there is no skew between data and control.
- Reset, applied while reset_n == 0 at a rising edge:
  - all three cnt = 0;
  - tmds_ch0/1/2 = 10'b1101010100;
  - any optional input register is cleared to Red/Green/Blue = 0, hs = vs = 1, active_nblank = 0.
- Reset asserted mid-line discards the in-flight pixel. The first post-reset output is computed from inputs sampled at the first edge with reset_n == 1.
- Switching from data to control takes effect on the same output cycle, with cnt cleared. Switching from control to data starts from cnt = 0.

## Configuration
- Macro: `TMDS_INPUT_REG_EN`.
- Defined:
  - Red, Green, Blue, hs, vs and active_nblank are registered before Stage A.
  - Latency is 2 cycles. All signals stay aligned with each other.
  - Breaks the long combinational path for 125 MHz+ serialiser clocking.
- Undefined: no input register; latency is 1 cycle.
- Tokens, codes and cnt sequences are identical in both builds, shifted by one cycle.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles with any inputs → all channels = 10'b1101010100 and cnt = 0. Release with active_nblank = 0, hs = 1, vs = 1 → tmds_ch0 = 10'b1010101011; ch1/ch2 = 10'b1101010100.
- Control tokens: active_nblank = 0, sweep {vs, hs} through 00/01/10/11 → tmds_ch0 = 1101010100 / 0010101011 / 0101010100 / 1010101011, each at the specified latency.
- Disparity run: after blanking, Blue = 0x00 for 2 pixels → ch0 = 10'h100 (cnt = −8), then 10'h3FF (cnt = +2).
- Saturated byte: after blanking, Green = 0xFF → ch1 = 10'h200 and cnt = −8.
- DC balance: 10,000 random pixels with active_nblank = 1, compared against a golden DVI model → bit-exact outputs; |cnt| ≤ 10 throughout; running ones-minus-zeros stays bounded.
- Mid-line reset: pulse reset_n low for 1 cycle during random data → the next output is 10'b1101010100 on all channels, and encoding resumes from cnt = 0. Repeat with TMDS_INPUT_REG_EN defined and check latency = 2.
